// File: rtl/fact_pkg.sv
// Shared types and constants for the memory-mapped factorial accelerator.
package fact_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StMult = 2'd2,
    StDone = 2'd3
  } fact_state_e;

  // Word offsets within the accelerator window (alu_out[3:2])
  localparam logic [1:0] OFF_N      = 2'd0;
  localparam logic [1:0] OFF_GO     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  // Largest N whose factorial still fits in 32 bits
  localparam int unsigned MaxNDefault = 12;

  // Busy covers every state in which a run is in flight
  function automatic logic state_busy(input fact_state_e st);
    return (st == StLoad) || (st == StMult);
  endfunction

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, running product and the two compare flags
// the control FSM branches on.
module fact_dp
  import fact_pkg::*;
#(
  parameter int unsigned NW    = 4,
  parameter int unsigned MAX_N = MaxNDefault
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,     // cnt <= n, prod <= 1
  input  logic          step_i,     // prod <= prod * cnt, cnt <= cnt - 1
  input  logic [NW-1:0] n_i,
  output logic [31:0]   prod_o,
  output logic          cnt_le1_o,
  output logic          n_gt_max_o
);

  logic [NW-1:0] cnt_q, cnt_d;
  logic [31:0]   prod_q, prod_d;
  logic [31:0]   cnt_ext;
  logic [31:0]   n_ext;

  assign cnt_ext = {{(32-NW){1'b0}}, cnt_q};
  assign n_ext   = {{(32-NW){1'b0}}, n_i};

  // Next-state: load wins over step; otherwise hold
  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (load_i) begin
      cnt_d  = n_i;
      prod_d = 32'd1;
    end else if (step_i) begin
      cnt_d  = cnt_q - NW'(1);
      prod_d = prod_q * cnt_ext;  // keep only the low 32 bits
    end
  end

  // Datapath registers; reset clears any partial product
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  // Compare flags seen by the FSM on the same cycle
  always_comb begin
    cnt_le1_o  = (cnt_q <= NW'(1));
    n_gt_max_o = (n_ext > MAX_N);
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator on the core's data-memory port.
// Software writes N, writes GO, polls STATUS and then reads RESULT.
module fact_accel
  import fact_pkg::*;
#(
  parameter int unsigned NW    = 4,
  parameter int unsigned MAX_N = MaxNDefault
) (
  input  logic        clk,
  input  logic        rst,    // active-low, asynchronous
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  fact_state_e   state_q;
  logic [NW-1:0] n_q;
  logic [31:0]   result_q;
  logic          done_q;
  logic          err_q;

  logic          wr_en;
  logic          n_wr;
  logic          go_wr;
  logic          busy;
  logic          dp_load;
  logic          dp_step;
  logic [31:0]   prod;
  logic          cnt_le1;
  logic          n_gt_max;
  logic          unused_wd;

  // Bus decode: writes only take effect while selected
  always_comb begin
    wr_en   = cs && we;
    n_wr    = wr_en && (a == OFF_N);
    go_wr   = wr_en && (a == OFF_GO) && wd[0];
    busy    = state_busy(state_q);
    dp_load = (state_q == StLoad);
    dp_step = (state_q == StMult) && !cnt_le1;
  end

  // Upper write-data bits are not stored anywhere
  assign unused_wd = ^wd;

  // N register: writable at any time; a run uses the copy taken in LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q <= '0;
    end else if (n_wr) begin
      n_q <= wd[NW-1:0];
    end
  end

  // Control FSM with registered done/err/result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (go_wr) begin
            state_q <= StLoad;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        StLoad: begin
          if (n_gt_max) begin
            state_q  <= StDone;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            result_q <= '0;
          end else begin
            state_q <= StMult;
          end
        end
        StMult: begin
          if (cnt_le1) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= prod;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fact_dp #(
    .NW    (NW),
    .MAX_N (MAX_N)
  ) u_dp (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (dp_load),
    .step_i     (dp_step),
    .n_i        (n_q),
    .prod_o     (prod),
    .cnt_le1_o  (cnt_le1),
    .n_gt_max_o (n_gt_max)
  );

  // Combinational read mux; zero when not selected
  always_comb begin
    rd = '0;
    if (cs) begin
      unique case (a)
        OFF_N:      rd = {{(32-NW){1'b0}}, n_q};
        OFF_GO:     rd = {31'b0, busy};
        OFF_STATUS: rd = {30'b0, err_q, done_q};
        OFF_RESULT: rd = result_q;
        default:    rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_accel.sv
// Scoreboard bench for fact_accel: expectations are queued at GO and
// compared when STATUS reports done.
module tb_fact_accel;
  import fact_pkg::*;

  typedef struct {
    logic [31:0] result;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs  = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  a   = 2'd0;
  logic [31:0] wd  = '0;
  logic [31:0] rd;

  int   n_checks = 0;
  int   n_errs   = 0;
  exp_t sb_q[$];

  fact_accel #(
    .NW    (4),
    .MAX_N (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cs  (cs),
    .we  (we),
    .a   (a),
    .wd  (wd),
    .rd  (rd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fact_model(input int n);
    logic [31:0] p = 32'd1;
    if (n > 12) return 32'd0;
    for (int i = 2; i <= n; i++) p = p * 32'(i);
    return p;
  endfunction

  function automatic int lat_model(input int n);
    if (n > 12) return 1;
    return ((n < 1) ? 1 : n) + 1;
  endfunction

  // Single-cycle bus write, captured at the next rising edge
  task automatic bus_wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; a = addr; wd = data;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; wd = '0;
  endtask

  // Zero-wait-state read, no clock edge consumed
  task automatic bus_rd(input logic [1:0] addr, output logic [31:0] v);
    cs = 1'b1; we = 1'b0; a = addr;
    #1;
    v = rd;
    cs = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      bus_rd(2'(i), v);
      check_eq($sformatf("%s_off%0d", tag, i), v, 32'd0);
    end
  endtask

  task automatic push_exp(input int n);
    exp_t e;
    e.result = fact_model(n);
    e.err    = (n > 12);
    e.lat    = lat_model(n);
    sb_q.push_back(e);
  endtask

  // Poll STATUS each cycle after E0 (k edges since GO), then score the run
  task automatic wait_done(input string tag, input int k0);
    logic [31:0] st;
    logic [31:0] v;
    exp_t        e;
    int          k = k0;
    bus_rd(OFF_STATUS, st);
    while (!st[0] && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      bus_rd(OFF_STATUS, st);
    end
    check_eq({tag, "_done"}, {31'b0, st[0]}, 32'd1);
    check_eq({tag, "_sb_nonempty"}, {31'b0, sb_q.size() > 0}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_lat"}, 32'(k), 32'(e.lat));
      check_eq({tag, "_err"}, {31'b0, st[1]}, {31'b0, e.err});
      bus_rd(OFF_RESULT, v);
      check_eq({tag, "_result"}, v, e.result);
      bus_rd(OFF_GO, v);
      check_eq({tag, "_busy_after"}, v, 32'd0);
    end
  endtask

  task automatic run_fact(input string tag, input int n);
    logic [31:0] v;
    bus_wr(OFF_N, 32'(n));
    push_exp(n);
    bus_wr(OFF_GO, 32'd1);
    // First cycle after GO: busy, done/err cleared
    bus_rd(OFF_GO, v);
    check_eq({tag, "_busy"}, v, 32'd1);
    bus_rd(OFF_STATUS, v);
    check_eq({tag, "_status_clr"}, v, 32'd0);
    wait_done(tag, 0);
  endtask

  initial begin
    logic [31:0] v;

    // Reset state
    repeat (2) @(posedge clk);
    check_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_rel");

    // Main function
    run_fact("n5", 5);
    run_fact("n12", 12);
    run_fact("n0", 0);
    run_fact("n1", 1);
    run_fact("n13", 13);
    run_fact("n4", 4);

    // Busy-run collisions: GO ignored, N updates the register only
    bus_wr(OFF_N, 32'd6);
    push_exp(6);
    bus_wr(OFF_GO, 32'd1);
    bus_wr(OFF_GO, 32'd1);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; a = OFF_N; wd = 32'd2;
    #1;
    check_eq("same_cycle_rd_n", rd, 32'd6);
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; wd = '0;
    wait_done("n6_coll", 2);
    bus_rd(OFF_N, v);
    check_eq("coll_n_readback", v, 32'd2);
    bus_wr(OFF_GO, 32'd1);
    push_exp(2);
    wait_done("n2_after", 0);

    // Deselected writes change nothing and read as zero
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cs = 1'b0; we = 1'b1; a = 2'(i); wd = 32'hFFFF_FFFF;
      #1;
      check_eq($sformatf("cs0_rd_off%0d", i), rd, 32'd0);
      @(posedge clk);
      #1;
      we = 1'b0; wd = '0;
    end
    bus_rd(OFF_N, v);
    check_eq("cs0_n", v, 32'd2);
    bus_rd(OFF_GO, v);
    check_eq("cs0_busy", v, 32'd0);
    bus_rd(OFF_STATUS, v);
    check_eq("cs0_status", v, 32'd1);
    bus_rd(OFF_RESULT, v);
    check_eq("cs0_result", v, 32'd2);

    // Reset while idle
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_idle");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_idle_rel");

    // Reset mid-MULT: N=10, LOAD then four multiplies
    bus_wr(OFF_N, 32'd10);
    bus_wr(OFF_GO, 32'd1);
    repeat (5) @(posedge clk);
    #3;
    bus_rd(OFF_GO, v);
    check_eq("mid_busy", v, 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mult");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mult_rel");
    run_fact("n3", 3);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
